zigbee_phase_diff_slicer: RTL and testbench

//  - Consumes the phase stream from the CORDIC phase stage (win/iValid) and forms a frequency discriminator.
//  - Takes the wrapped phase difference between consecutive valid samples and integrates it over OSR samples.
//  - Slices each integral to one chip (MSK/O-QPSK frequency sign).
//  - Packs chips into 32-chip words for the downstream despreader.

---
 rtl/zigbee_phase_diff_slicer.sv | 172 +++++++++++++++++
 tb/tb_zigbee_phase_diff_slicer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_phase_diff_slicer.sv
// -----------------------------------------------------------------------------
// zigbee_phase_diff_slicer
//
// Purpose:
//   Frequency discriminator for the O-QPSK/MSK receive path. Takes the wrapped
//   phase difference between consecutive valid CORDIC phase samples, integrates
//   OSR differences per chip, slices each integral to one chip (1 = positive
//   frequency) and packs CHIPS_PER_WORD chips into a word for the despreader.
//
// Ports:
//   clk         in   1               clock, rising edge
//   reset_n     in   1               asynchronous reset, active-low
//   win         in   W_SIZE          signed phase, full scale 2^W_SIZE = 360 deg
//   iValid      in   1               win qualifier, gaps of any length allowed
//   align       in   1               synchronous restart of chip/word timing
//   chip_out    out  1               sliced chip, 1 = positive frequency
//   chip_valid  out  1               one-cycle pulse, chip_out valid
//   chip_word   out  CHIPS_PER_WORD  packed chips, first chip at MSB
//   word_valid  out  1               one-cycle pulse, chip_word valid
// -----------------------------------------------------------------------------
module zigbee_phase_diff_slicer #(
  parameter int W_SIZE         = 6,
  parameter int OSR            = 4,
  parameter int CHIPS_PER_WORD = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [W_SIZE-1:0]         win,
  input  logic                      iValid,
  input  logic                      align,
  output logic                      chip_out,
  output logic                      chip_valid,
  output logic [CHIPS_PER_WORD-1:0] chip_word,
  output logic                      word_valid
);

  localparam int ACC_SIZE = W_SIZE + $clog2(OSR) + 1;
  localparam int SC_W     = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int CC_W     = (CHIPS_PER_WORD > 1) ? $clog2(CHIPS_PER_WORD) : 1;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OSR - 1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(CHIPS_PER_WORD - 1);
  localparam logic [CC_W-1:0] CC_ONE  = CC_W'(1);

  // State registers
  logic [W_SIZE-1:0]         prev_phase_r;
  logic                      ref_ok_r;
  logic [ACC_SIZE-1:0]       acc_r;
  logic [SC_W-1:0]           sample_cnt_r;
  logic [CC_W-1:0]           chip_cnt_r;
  logic [CHIPS_PER_WORD-2:0] shreg_r;
  logic                      chip_out_r;
  logic                      chip_valid_r;
  logic [CHIPS_PER_WORD-1:0] chip_word_r;
  logic                      word_valid_r;

  // Combinational datapath
  logic [W_SIZE-1:0]   d_s;
  logic [ACC_SIZE-1:0] d_ext_s;
  logic [ACC_SIZE-1:0] sum_s;
  logic                diff_en_s;
  logic                chip_end_s;
  logic                word_end_s;
  logic                chip_s;

  // Wrapped phase difference, integration and chip/word completion decode
  always_comb begin
    d_s        = {W_SIZE{1'b0}};
    d_ext_s    = {ACC_SIZE{1'b0}};
    sum_s      = {ACC_SIZE{1'b0}};
    diff_en_s  = 1'b0;
    chip_end_s = 1'b0;
    word_end_s = 1'b0;
    chip_s     = 1'b0;

    // W_SIZE-bit subtraction wraps naturally into [-180, +180) deg
    d_s     = win - prev_phase_r;
    d_ext_s = {{(ACC_SIZE-W_SIZE){d_s[W_SIZE-1]}}, d_s};
    sum_s   = acc_r + d_ext_s;

    if (iValid && ref_ok_r && !align) begin
      diff_en_s = 1'b1;
    end else begin
      diff_en_s = 1'b0;
    end

    if (diff_en_s && (sample_cnt_r == SC_LAST)) begin
      chip_end_s = 1'b1;
    end else begin
      chip_end_s = 1'b0;
    end

    if (chip_end_s && (chip_cnt_r == CC_LAST)) begin
      word_end_s = 1'b1;
    end else begin
      word_end_s = 1'b0;
    end

    // A zero integral slices to 0: strictly positive only
    if (!sum_s[ACC_SIZE-1] && (sum_s != {ACC_SIZE{1'b0}})) begin
      chip_s = 1'b1;
    end else begin
      chip_s = 1'b0;
    end
  end

  // Reference tracking, integration, slicing and chip packing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_phase_r <= {W_SIZE{1'b0}};
      ref_ok_r     <= 1'b0;
      acc_r        <= {ACC_SIZE{1'b0}};
      sample_cnt_r <= {SC_W{1'b0}};
      chip_cnt_r   <= {CC_W{1'b0}};
      shreg_r      <= {(CHIPS_PER_WORD-1){1'b0}};
      chip_out_r   <= 1'b0;
      chip_valid_r <= 1'b0;
      chip_word_r  <= {CHIPS_PER_WORD{1'b0}};
      word_valid_r <= 1'b0;
    end else if (align) begin
      // Partial chip/word is dropped; chip_out and chip_word keep last values
      acc_r        <= {ACC_SIZE{1'b0}};
      sample_cnt_r <= {SC_W{1'b0}};
      chip_cnt_r   <= {CC_W{1'b0}};
      shreg_r      <= {(CHIPS_PER_WORD-1){1'b0}};
      chip_valid_r <= 1'b0;
      word_valid_r <= 1'b0;
      if (iValid) begin
        prev_phase_r <= win;
        ref_ok_r     <= 1'b1;
      end else begin
        ref_ok_r     <= 1'b0;
      end
    end else begin
      chip_valid_r <= 1'b0;
      word_valid_r <= 1'b0;
      if (iValid) begin
        prev_phase_r <= win;
        ref_ok_r     <= 1'b1;
      end else begin
        prev_phase_r <= prev_phase_r;
      end

      if (chip_end_s) begin
        acc_r        <= {ACC_SIZE{1'b0}};
        sample_cnt_r <= {SC_W{1'b0}};
        chip_out_r   <= chip_s;
        chip_valid_r <= 1'b1;
        shreg_r      <= {shreg_r[CHIPS_PER_WORD-3:0], chip_s};
        if (word_end_s) begin
          chip_word_r  <= {shreg_r, chip_s};
          word_valid_r <= 1'b1;
          chip_cnt_r   <= {CC_W{1'b0}};
        end else begin
          chip_cnt_r   <= chip_cnt_r + CC_ONE;
        end
      end else if (diff_en_s) begin
        acc_r        <= sum_s;
        sample_cnt_r <= sample_cnt_r + SC_ONE;
      end else begin
        acc_r        <= acc_r;
      end
    end
  end

  assign chip_out   = chip_out_r;
  assign chip_valid = chip_valid_r;
  assign chip_word  = chip_word_r;
  assign word_valid = word_valid_r;

endmodule

// File: tb/tb_zigbee_phase_diff_slicer.sv
// -----------------------------------------------------------------------------
// tb_zigbee_phase_diff_slicer
//
// Self-checking bench: table-driven vectors for the basic chip behaviour,
// directed sequences for wrap, word packing, align and async reset, and a
// randomized run checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_zigbee_phase_diff_slicer;

  localparam int W_SIZE = 6;
  localparam int OSR    = 4;
  localparam int CPW    = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [5:0]     win = 6'd0;
  logic           iValid = 1'b0;
  logic           align = 1'b0;
  logic           chip_out;
  logic           chip_valid;
  logic [31:0]    chip_word;
  logic           word_valid;

  zigbee_phase_diff_slicer #(
    .W_SIZE(W_SIZE), .OSR(OSR), .CHIPS_PER_WORD(CPW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .win(win), .iValid(iValid), .align(align),
    .chip_out(chip_out), .chip_valid(chip_valid),
    .chip_word(chip_word), .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: phase values as integers, pending differences and chips
  int          m_prev;
  bit          m_ref;
  int          m_diffs[$];
  bit          m_chips[$];
  bit          e_cv, e_co, e_wv;
  logic [31:0] e_cw;

  // Per-scenario observation counters
  int cv_seen, wv_seen, ones_seen;

  typedef struct {
    logic       rst_before;
    logic       v;
    logic [5:0] w;
    logic       e_cv;
    logic       e_co;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap_diff(input int x);
    return ((x % 64) + 64 + 32) % 64 - 32;
  endfunction

  function automatic void model_reset();
    m_prev = 0;
    m_ref  = 1'b0;
    m_diffs.delete();
    m_chips.delete();
    e_cv = 1'b0; e_co = 1'b0; e_wv = 1'b0; e_cw = 32'd0;
  endfunction

  function automatic void model_step(input bit v, input logic [5:0] w, input bit al);
    int ws;
    int s;
    logic [31:0] word;
    ws   = int'($signed(w));
    e_cv = 1'b0;
    e_wv = 1'b0;
    if (al) begin
      m_diffs.delete();
      m_chips.delete();
      m_ref = v;
      if (v) m_prev = ws;
    end else if (v) begin
      if (!m_ref) begin
        m_ref  = 1'b1;
        m_prev = ws;
      end else begin
        m_diffs.push_back(wrap_diff(ws - m_prev));
        m_prev = ws;
        if (m_diffs.size() == OSR) begin
          s = 0;
          foreach (m_diffs[i]) s += m_diffs[i];
          m_diffs.delete();
          e_co = (s > 0);
          e_cv = 1'b1;
          m_chips.push_back(e_co);
          if (m_chips.size() == CPW) begin
            word = 32'd0;
            foreach (m_chips[i]) word = {word[30:0], m_chips[i]};
            e_cw = word;
            e_wv = 1'b1;
            m_chips.delete();
          end
        end
      end
    end
  endfunction

  // One clock: drive inputs, advance the model, compare outputs 1 ns after the edge
  task automatic step(input bit v, input logic [5:0] w, input bit al);
    iValid = v;
    win    = w;
    align  = al;
    @(posedge clk);
    model_step(v, w, al);
    #1;
    chk("cyc_chip_valid", 32'(chip_valid), 32'(e_cv));
    chk("cyc_word_valid", 32'(word_valid), 32'(e_wv));
    chk("cyc_chip_out",   32'(chip_out),   32'(e_co));
    chk("cyc_chip_word",  chip_word,       e_cw);
    if (chip_valid) begin
      cv_seen++;
      if (chip_out) ones_seen++;
    end
    if (word_valid) wv_seen++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    iValid  = 1'b0;
    align   = 1'b0;
    model_reset();
    #2;
    chk("rst_chip_valid", 32'(chip_valid), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_chip_out",   32'(chip_out),   32'd0);
    chk("rst_chip_word",  chip_word,       32'd0);
    #10;
    reset_n = 1'b1;
    cv_seen = 0; wv_seen = 0; ones_seen = 0;
  endtask

  initial begin
    int ph;
    int first_wv;
    int r;

    // Table: 9 zero samples, then a +4 ramp through the 60 -> 0 wrap after reset
    for (int i = 0; i < 26; i++) begin
      if (i < 9) begin
        tbl[i].rst_before = (i == 0);
        tbl[i].v    = 1'b1;
        tbl[i].w    = 6'd0;
        tbl[i].e_cv = (i == 4) || (i == 8);
        tbl[i].e_co = 1'b0;
      end else begin
        tbl[i].rst_before = (i == 9);
        tbl[i].v    = 1'b1;
        tbl[i].w    = 6'(4 * (i - 9));
        tbl[i].e_cv = ((i - 9) == 4) || ((i - 9) == 8) || ((i - 9) == 12) || ((i - 9) == 16);
        tbl[i].e_co = tbl[i].e_cv;
      end
    end

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].rst_before) do_reset();
      step(tbl[i].v, tbl[i].w, 1'b0);
      chk("tbl_chip_valid", 32'(chip_valid), 32'(tbl[i].e_cv));
      chk("tbl_word_valid", 32'(word_valid), 32'd0);
      if (tbl[i].e_cv) chk("tbl_chip_out", 32'(chip_out), 32'(tbl[i].e_co));
    end

    // Descending ramp with 0 -> -4 wrap: all chips 0
    do_reset();
    for (int k = 0; k < 13; k++) step(1'b1, 6'(-4 * k), 1'b0);
    chk("desc_chips", 32'(cv_seen), 32'd3);
    chk("desc_ones",  32'(ones_seen), 32'd0);
    // Boundary step 31 -> -32 is +1, so the chip stays positive
    step(1'b1, 6'd31, 1'b1);
    step(1'b1, 6'h20, 1'b0);
    step(1'b1, 6'h21, 1'b0);
    step(1'b1, 6'h22, 1'b0);
    step(1'b1, 6'h23, 1'b0);
    chk("wrap31_chip_valid", 32'(chip_valid), 32'd1);
    chk("wrap31_chip_out",   32'(chip_out),   32'd1);

    // Alternating direction every OSR differences, random gaps: one 0xAAAAAAAA word
    do_reset();
    ph = 0;
    step(1'b1, 6'(ph), 1'b0);
    for (int c = 0; c < CPW; c++) begin
      for (int k = 0; k < OSR; k++) begin
        r = int'($urandom_range(3, 0));
        for (int g = 0; g < r; g++) step(1'b0, 6'($urandom), 1'b0);
        ph = ph + ((c % 2 == 0) ? 4 : -4);
        step(1'b1, 6'(ph), 1'b0);
      end
    end
    chk("alt_last_chip_valid", 32'(chip_valid), 32'd1);
    chk("alt_last_word_valid", 32'(word_valid), 32'd1);
    chk("alt_word", chip_word, 32'hAAAAAAAA);
    chk("alt_word_count", 32'(wv_seen), 32'd1);
    chk("alt_chip_count", 32'(cv_seen), 32'd32);

    // align with iValid after 10 chips: partial data dropped, new word after 32*OSR samples
    do_reset();
    step(1'b1, 6'($urandom), 1'b0);
    for (int k = 0; k < 10 * OSR; k++) step(1'b1, 6'($urandom), 1'b0);
    chk("pre_align_chips", 32'(cv_seen), 32'd10);
    step(1'b1, 6'($urandom), 1'b1);
    chk("align_chip_valid", 32'(chip_valid), 32'd0);
    chk("align_word_valid", 32'(word_valid), 32'd0);
    first_wv = 0;
    for (int n = 1; n <= 32 * OSR; n++) begin
      step(1'b1, 6'($urandom), 1'b0);
      if (word_valid && first_wv == 0) first_wv = n;
    end
    chk("align_word_at", 32'(first_wv), 32'(32 * OSR));

    // Async reset mid-chip while chip_valid is high, then scenario 1 again
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 6'd8 + 6'(3 * k), 1'b0);
    chk("pre_rst_chip_valid", 32'(chip_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_chip_valid", 32'(chip_valid), 32'd0);
    chk("async_chip_out",   32'(chip_out),   32'd0);
    chk("async_word_valid", 32'(word_valid), 32'd0);
    chk("async_chip_word",  chip_word,       32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    cv_seen = 0; wv_seen = 0; ones_seen = 0;
    for (int k = 0; k < 9; k++) step(1'b1, 6'd0, 1'b0);
    chk("post_rst_chips", 32'(cv_seen), 32'd2);
    chk("post_rst_ones",  32'(ones_seen), 32'd0);
    chk("post_rst_words", 32'(wv_seen), 32'd0);

    // Randomized run: gaps, occasional align, random phases and slow ramps
    do_reset();
    ph = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(3, 0) == 0) ph = ph + int'($urandom_range(63, 0));
      else ph = ph + int'($urandom_range(12, 0)) - 6;
      step(($urandom_range(3, 0) != 0), 6'(ph), ($urandom_range(99, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
